if_fetch_unit: RTL

//  Instruction-fetch stage: owns the PC, drives the synchronous instruction

---
 rtl/if_fetch_unit.sv | 96 +++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage.
// Owns the PC, drives the synchronous instruction memory, and requests IF/ID
// bubbles. Handles load-use stalls (hold) and EX-stage redirects.
module if_fetch_unit #(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned ADDR_SIZE = 10,
    parameter int unsigned RESET_PC  = 0,
    parameter int unsigned COUNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [ADDR_SIZE+1:0] redirect_pc,
    output logic [ADDR_SIZE+1:0] pc_if,
    output logic [ADDR_SIZE-1:0] imem_addr,
    output logic                 imem_en,
    output logic                 clear_if_id,
    output logic                 misaligned,
    output logic [COUNT_W-1:0]   fetch_count
);

    localparam int unsigned PC_W = ADDR_SIZE + 2;
    localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC);

    // Elaboration-time sanity check on the parameter set.
    if ((RESET_PC % 4) != 0 || DATA_SIZE == 0) begin : g_param_check
        $error("if_fetch_unit: RESET_PC must be 4-aligned and DATA_SIZE nonzero");
    end

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HOLD
    } state_t;

    state_t          state;
    logic [PC_W-1:0] pc_q;

    assign pc_if     = pc_q;
    assign imem_addr = pc_q[PC_W-1:2];

    // imem_en and clear_if_id must react to stall/redirect within the same
    // cycle, so they are decoded from the registered state rather than stored.
    always_comb begin
        imem_en     = 1'b0;
        clear_if_id = 1'b0;
        if (state == BOOT) begin
            clear_if_id = 1'b1;
        end else if (redirect) begin
            imem_en     = 1'b1;
            clear_if_id = 1'b1;
        end else if (!stall) begin
            imem_en = 1'b1;
        end
    end

    // State, PC and sticky misalignment flag; redirect outranks stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BOOT;
            pc_q       <= RESET_PC_V;
            misaligned <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state <= RUN;
                end
                default: begin
                    if (redirect) begin
                        pc_q  <= {redirect_pc[PC_W-1:2], 2'b00};
                        state <= RUN;
                        if (redirect_pc[1:0] != 2'b00) begin
                            misaligned <= 1'b1;
                        end
                    end else if (stall) begin
                        state <= HOLD;
                    end else begin
                        pc_q  <= pc_q + PC_W'(4);
                        state <= RUN;
                    end
                end
            endcase
        end
    end

    // Saturating count of fetches that were not squashed by a redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= '0;
        end else if (imem_en && !redirect && (fetch_count != '1)) begin
            fetch_count <= fetch_count + COUNT_W'(1);
        end
    end

endmodule
